disp_scheduler: RTL

Time-shares the 3-digit seven-segment display between four 8-bit requesters, for example the accumulator, the program counter, the output port and a debug source. It runs a round-robin arbiter with a per-source dwell time and snapshots the granted source's byte into the value register that feeds the display multiplexer. It also generates the digit-scan enable pulse that paces the multiplexer.

---
 rtl/disp_scheduler.sv | 123 ++++++++++++
 1 files changed

// File: rtl/disp_scheduler.sv
// Round-robin display scheduler: four byte sources share one display, each holding it for a
// DWELL_TICKS-scan dwell. Optional Blank output is enabled with `define DISP_BLANK_EN.
module disp_scheduler #(
  parameter int CLK_DIV     = 4,
  parameter int DWELL_TICKS = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [3:0]  Req,
  input  logic [31:0] Src_data,
  output logic [3:0]  Grant,
  output logic [1:0]  Src_id,
  output logic [7:0]  Disp_data,
  output logic        Scan_en,
  output logic        Busy
`ifdef DISP_BLANK_EN
  ,
  output logic        Blank
`endif
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = $clog2(DWELL_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [1:0]      last_q, sel_q, sel_d, pick_idx, srcid_q;
  logic [7:0]      disp_q;
  logic            pick_vld, cap, done;

  // Free-running scan prescaler, unaffected by the FSM.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                             presc_q <= '0;
    else if (presc_q == PW'(CLK_DIV-1))  presc_q <= '0;
    else                                 presc_q <= presc_q + 1'b1;
  end

  assign Scan_en = (presc_q == PW'(CLK_DIV-1));

  // First requester after `last`; `last` itself only when it is the sole requester.
  always_comb begin
    pick_vld = |Req;
    pick_idx = last_q;
    for (int k = 3; k >= 1; k--)
      if (Req[last_q + 2'(k)]) pick_idx = last_q + 2'(k);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dwell_d = dwell_q;
    Grant   = '0;
    cap     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: if (pick_vld) begin
        sel_d   = pick_idx;
        state_d = S_GRANT;
      end
      S_GRANT: begin
        Grant   = 4'b0001 << sel_q;
        cap     = 1'b1;
        dwell_d = '0;
        state_d = S_HOLD;
      end
      S_HOLD: if (Scan_en) begin
        if (dwell_q == DW'(DWELL_TICKS-1)) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      disp_q  <= '0;
      srcid_q <= '0;
      last_q  <= 2'd3;
    end else if (cap) begin
      disp_q  <= Src_data[sel_q*8 +: 8];
      srcid_q <= sel_q;
      last_q  <= sel_q;
    end
  end

  assign Disp_data = disp_q;
  assign Src_id    = srcid_q;
  assign Busy      = (state_q != S_IDLE);

`ifdef DISP_BLANK_EN
  logic blank_q;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                     blank_q <= 1'b1;
    else if (cap)                blank_q <= 1'b0;
    else if (done && Req == '0)  blank_q <= 1'b1;
  end
  assign Blank = blank_q;
`else
  // done only drives Blank; keep it referenced in the default build.
  logic unused_done;
  assign unused_done = done;
`endif

endmodule
